data_mem_responder: RTL and testbench

- Responder for the pipelined core's memory-stage data port.
- Takes MemWriteM, Mem_WrAddr, Mem_WrData and InstrM from the datapath and returns ReadDataM in the same cycle.
- Provides a byte-enabled data RAM with RV32I load/store width handling and sign/zero extension.
- Provides an MMIO window with a 64-bit cycle counter, a status register, and a buffered output port with a valid/ready handshake.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 46 ++++
 rtl/data_mem_responder.sv | 103 ++++++++++
 tb/tb_data_mem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: opcode, funct3, MMIO offset and status bit constants for the data-memory responder
package dmem_pkg;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_LB = 3'b000;
  localparam logic [2:0] F3_LH = 3'b001;
  localparam logic [2:0] F3_LW = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [1:0] OFF_OUT = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE_LO = 2'd2;
  localparam logic [1:0] OFF_CYCLE_HI = 2'd3;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_MIS = 2;
  localparam int ST_OVF = 3;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} size_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO whose head output holds the last popped word while empty
module sync_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_pop, do_push;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign count = cnt_q;
  assign dout = mem[empty ? rp_q - AW'(1) : rp_q];
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wp_d = wp_q + AW'(do_push);
    rp_d = rp_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q] <= din;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: M-stage data RAM with RV32I width handling plus cycle-counter/status/output-FIFO MMIO
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  input  logic [31:0] InstrM,
  output logic [31:0] ReadDataM,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_flag
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] mem [DEPTH];
  logic [2:0] f3;
  size_e sz;
  logic is_ld, is_st, ok, mis, in_ram, in_mmio, hit, ram_we, mm_ok, mis_set, ovf_set, st_wr;
  logic push, pop, full, empty;
  logic [CW-1:0] count;
  logic [1:0] off;
  logic [3:0] be;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] wdata, word, ram_rd, mm_rd, status;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic mis_q, mis_d, ovf_q, ovf_d;
  logic unused_ok;
  assign unused_ok = &{1'b0, InstrM[31:15], InstrM[11:7]};
  assign f3 = InstrM[14:12];
  assign cnt_d = cnt_q + 64'd1;
  assign status = {28'b0, ovf_q, mis_q, empty, full};
  assign err_flag = mis_q || ovf_q;
  assign out_valid = !empty;
  always_comb begin
    is_st = MemWriteM;
    is_ld = !MemWriteM && InstrM[6:0] == OP_LOAD;
    sz = size_e'(f3[1:0]);
    ok = (is_st || is_ld) && sz != SZ_X && !(f3[2] && (is_st || sz == SZ_W));
    mis = ok && ((sz == SZ_H && Mem_WrAddr[0]) || (sz == SZ_W && Mem_WrAddr[1:0] != 2'b00));
    in_ram = Mem_WrAddr < 32'(DEPTH * 4);
    in_mmio = Mem_WrAddr[31:4] == MMIO_BASE[31:4];
    hit = ok && !mis;
    ram_we = is_st && hit && in_ram;
    mm_ok = hit && in_mmio && sz == SZ_W;
    off = Mem_WrAddr[3:2];
    be = sz == SZ_B ? 4'b0001 << Mem_WrAddr[1:0] : sz == SZ_H ? (Mem_WrAddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = sz == SZ_B ? {4{Mem_WrData[7:0]}} : sz == SZ_H ? {2{Mem_WrData[15:0]}} : Mem_WrData;
    word = mem[Mem_WrAddr[AW+1:2]];
    b = word[8*Mem_WrAddr[1:0] +: 8];
    h = Mem_WrAddr[1] ? word[31:16] : word[15:0];
    ram_rd = sz == SZ_B ? {{24{!f3[2] && b[7]}}, b} : sz == SZ_H ? {{16{!f3[2] && h[15]}}, h} : word;
    mm_rd = off == OFF_OUT ? 32'(count) : off == OFF_STATUS ? status :
            off == OFF_CYCLE_LO ? cnt_q[31:0] : shadow_q;
    ReadDataM = !(is_ld && hit) ? 32'd0 : in_ram ? ram_rd : mm_ok ? mm_rd : 32'd0;
    // a push into a full FIFO still succeeds when the consumer frees the head on the same edge
    pop = !empty && out_ready;
    push = is_st && mm_ok && off == OFF_OUT && (!full || pop);
    ovf_set = is_st && mm_ok && off == OFF_OUT && full && !pop;
    mis_set = mis && (in_ram || in_mmio);
    st_wr = is_st && mm_ok && off == OFF_STATUS;
    mis_d = mis_set || (mis_q && !(st_wr && Mem_WrData[ST_MIS]));
    ovf_d = ovf_set || (ovf_q && !(st_wr && Mem_WrData[ST_OVF]));
    shadow_d = is_ld && mm_ok && off == OFF_CYCLE_LO ? cnt_q[63:32] : shadow_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      shadow_q <= '0;
      mis_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      mis_q <= mis_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we && be[i]) mem[Mem_WrAddr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
  end
  sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(push),
    .pop(pop),
    .din(Mem_WrData),
    .dout(out_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed stimulus with a byte-addressed reference model checked every cycle
module tb_data_mem_responder;
  localparam logic [6:0] LD = 7'h03;
  localparam logic [6:0] ST = 7'h23;
  localparam logic [6:0] ALU = 7'h13;
  localparam logic [31:0] BASE = 32'h1000_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic MemWriteM = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] Mem_WrAddr = '0, Mem_WrData = '0, InstrM = '0;
  logic [31:0] ReadDataM, out_data;
  logic out_valid, err_flag;
  int n_chk = 0, n_fail = 0;
  logic [7:0] mram [int unsigned];
  int q[$];
  logic [63:0] mcnt = '0;
  logic [31:0] mshadow = '0;
  bit mmis = 0, movf = 0, armed = 0;
  logic [31:0] rd, od;
  logic ev, eerr;
  data_mem_responder dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .Mem_WrAddr(Mem_WrAddr),
    .Mem_WrData(Mem_WrData), .InstrM(InstrM), .ReadDataM(ReadDataM), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .err_flag(err_flag)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // reference model: sample at the falling edge, then advance state as the next rising edge will
  always @(negedge clk) begin : model
    logic [31:0] a, exp_rd;
    logic [2:0] f3;
    bit ld, st, ok, mis, ram, mm, known, pop, mset, oset, mclr, oclr;
    int nb, sz0;
    a = Mem_WrAddr;
    f3 = InstrM[14:12];
    st = MemWriteM;
    ld = !st && InstrM[6:0] == LD;
    nb = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : f3[1:0] == 2'd2 ? 4 : 0;
    ok = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : ld && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = ok && nb > 1 && (a % nb != 0);
    ram = a < 32'd4096;
    mm = a >= BASE && a < BASE + 32'd16;
    if (armed) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      if (q.size() > 0) check("out_data", out_data, q[0]);
      check("err_flag", {31'b0, err_flag}, {31'b0, mmis || movf});
      if (!st) begin
        known = 1;
        exp_rd = 0;
        if (ld && ok && !mis && ram) begin
          for (int i = 0; i < nb; i++)
            if (mram.exists(a + i)) exp_rd |= 32'(mram[a + i]) << (8 * i);
            else known = 0;
          if (!f3[2] && nb < 4 && exp_rd[8*nb-1]) exp_rd |= ~((32'd1 << (8 * nb)) - 32'd1);
        end else if (ld && ok && !mis && mm && nb == 4) begin
          if (a == BASE) exp_rd = q.size();
          else if (a == BASE + 4) exp_rd = {28'b0, movf, mmis, q.size() == 0, q.size() == 4};
          else if (a == BASE + 8) exp_rd = mcnt[31:0];
          else exp_rd = mshadow;
        end
        if (known) check("ReadDataM", ReadDataM, exp_rd);
      end
    end
    if (reset) begin
      q.delete();
      mcnt = 0;
      mshadow = 0;
      mmis = 0;
      movf = 0;
      armed = 1;
    end else begin
      sz0 = q.size();
      pop = sz0 > 0 && out_ready;
      if (pop) void'(q.pop_front());
      mset = mis && (ram || mm);
      oset = 0;
      mclr = 0;
      oclr = 0;
      if (st && ok && !mis && ram)
        for (int i = 0; i < nb; i++) mram[a + i] = Mem_WrData[8*i +: 8];
      if (st && ok && !mis && mm && nb == 4) begin
        if (a == BASE) begin
          if (sz0 < 4 || pop) q.push_back(int'(Mem_WrData));
          else oset = 1;
        end
        if (a == BASE + 4) begin
          mclr = Mem_WrData[2];
          oclr = Mem_WrData[3];
        end
      end
      if (ld && ok && !mis && mm && nb == 4 && a == BASE + 8) mshadow = mcnt[63:32];
      mmis = mset || (mmis && !mclr);
      movf = oset || (movf && !oclr);
      mcnt = mcnt + 64'd1;
    end
  end
  task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input logic [6:0] op, input bit rdy);
    MemWriteM = we;
    Mem_WrAddr = a;
    Mem_WrData = d;
    InstrM = {17'b0, f3, 5'b0, op};
    out_ready = rdy;
    @(negedge clk);
    rd = ReadDataM;
    od = out_data;
    ev = out_valid;
    eerr = err_flag;
    @(posedge clk);
    #1;
  endtask
  task automatic sto(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3, input bit rdy = 0);
    cyc(1, a, d, f3, ST, rdy);
  endtask
  task automatic lod(input logic [31:0] a, input logic [2:0] f3);
    cyc(0, a, 32'h0, f3, LD, 0);
  endtask
  task automatic nop(input bit rdy = 0);
    cyc(0, 32'h10, 32'h0, 3'd2, ALU, rdy);
  endtask
  initial begin
    repeat (3) nop();
    reset = 1'b0;
    nop();
    check("rst_valid", {31'b0, ev}, 32'd0);
    check("rst_err", {31'b0, eerr}, 32'd0);
    sto(32'h10, 32'hDEAD_BEEF, 3'd2);
    lod(32'h13, 3'd0); check("lb", rd, 32'hFFFF_FFDE);
    lod(32'h13, 3'd4); check("lbu", rd, 32'h0000_00DE);
    lod(32'h12, 3'd1); check("lh", rd, 32'hFFFF_DEAD);
    lod(32'h10, 3'd5); check("lhu", rd, 32'h0000_BEEF);
    lod(32'h10, 3'd2); check("lw", rd, 32'hDEAD_BEEF);
    sto(32'h11, 32'hAAAA_AA55, 3'd0);
    lod(32'h10, 3'd2); check("sb_merge", rd, 32'hDEAD_55EF);
    sto(32'h12, 32'h1234_5678, 3'd2);
    lod(32'h10, 3'd2); check("mis_sw_kept", rd, 32'hDEAD_55EF); check("mis_err", {31'b0, eerr}, 32'd1);
    lod(BASE + 4, 3'd2); check("status_mis", rd, 32'h6);
    sto(BASE + 4, 32'h4, 3'd2);
    nop(); check("mis_clr", {31'b0, eerr}, 32'd0);
    lod(32'h2000, 3'd2); check("unmapped", rd, 32'd0);
    nop(); check("unmapped_noflag", {31'b0, eerr}, 32'd0);
    lod(BASE + 8, 3'd0); check("mmio_byte", rd, 32'd0);
    cyc(0, 32'h10, 32'h0, 3'd2, ALU, 0); check("bubble", rd, 32'd0);
    lod(32'h11, 3'd1); check("mis_lh", rd, 32'd0);
    nop(); check("mis_lh_err", {31'b0, eerr}, 32'd1);
    sto(BASE + 4, 32'h4, 3'd2);
    for (int v = 1; v <= 5; v++) sto(BASE, 32'(v), 3'd2, 0);
    lod(BASE, 3'd2); check("fifo_cnt", rd, 32'd4); check("ovf_err", {31'b0, eerr}, 32'd1);
    lod(BASE + 4, 3'd2); check("status_ovf", rd, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      nop(1);
      check("drain_data", od, 32'(k));
      check("drain_valid", {31'b0, ev}, 32'd1);
    end
    nop(); check("drained", {31'b0, ev}, 32'd0);
    sto(BASE + 4, 32'h8, 3'd2);
    for (int v = 10; v <= 13; v++) sto(BASE, 32'(v), 3'd2, 0);
    sto(BASE, 32'd14, 3'd2, 1); check("pp_head", od, 32'd10);
    lod(BASE, 3'd2); check("pp_cnt", rd, 32'd4); check("pp_noovf", {31'b0, eerr}, 32'd0);
    for (int k = 11; k <= 14; k++) begin
      nop(1);
      check("pp_order", od, 32'(k));
    end
    nop(); check("pp_drained", {31'b0, ev}, 32'd0);
    force dut.cnt_d = 64'h0000_0000_FFFF_FFFF;
    nop();
    release dut.cnt_d;
    mcnt = 64'h0000_0000_FFFF_FFFF;
    lod(BASE + 8, 3'd2); check("cyc_lo", rd, 32'hFFFF_FFFF);
    lod(BASE + 12, 3'd2); check("cyc_hi", rd, 32'h0);
    lod(BASE + 8, 3'd2); check("cyc_lo2", rd, 32'h1);
    lod(BASE + 12, 3'd2); check("cyc_hi2", rd, 32'h1);
    sto(BASE, 32'd7, 3'd2, 0);
    sto(BASE, 32'd8, 3'd2, 0);
    reset = 1'b1;
    nop(1);
    reset = 1'b0;
    nop(); check("rst_flush", {31'b0, ev}, 32'd0);
    lod(BASE + 8, 3'd2); check("rst_cnt", rd, 32'd1);
    lod(BASE, 3'd2); check("rst_fifo_cnt", rd, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
